tff_bank_scheduler: RTL



---
 rtl/tff_bank_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/tff_bank_scheduler.sv
// Round-robin scheduler serialising N_REQ requesters onto one shared bank of WIDTH T flip-flops (q <= q ^ mask).
// Latency: req sampled in IDLE at E0 -> gnt during E0..E1 -> done during E1..E2 -> new q visible after E2; 1 op / 3 cycles.
// Backpressure: requesters hold req/mask until gnt is seen; a req still high in the next IDLE cycle is a new request.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req [N_REQ]   per-requester request level
//   mask          packed toggle masks, requester i owns bits [i*WIDTH +: WIDTH]
//   clr           synchronous clear of the bank (wins over a pending toggle)
//   gnt [N_REQ]   registered one-hot grant, high for the single GRANT cycle
//   q, q_bar      bank state and its complement
//   done, done_id one-cycle pulse in APPLY and the index being applied
//   busy          high in GRANT and APPLY
module tff_bank_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] mask,
    input  logic                   clr,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_bar,
    output logic                   done,
    output logic [SEL_W-1:0]       done_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   mask_r;
    logic               win_found;
    logic [SEL_W-1:0]   win_idx;

    // Search starts at ptr and wraps; the first requester found wins.
    // ptr is moved just past the last winner, so that winner ranks last next time.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && req[(int'(ptr) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = GRANT;
            GRANT:   state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, winner index, captured mask and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            sel    <= '0;
            mask_r <= '0;
            ptr    <= '0;
        end else begin
            gnt <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        gnt <= N_REQ'(1) << win_idx;
                        sel <= win_idx;
                    end
                end
                GRANT: begin
                    // Captured even if the requester already dropped req.
                    mask_r <= mask[int'(sel)*WIDTH +: WIDTH];
                    ptr    <= (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bank update: clr discards a coinciding toggle but leaves the FSM untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (state_q == APPLY) begin
            q <= q ^ mask_r;
        end
    end

    assign q_bar   = ~q;
    assign done    = (state_q == APPLY);
    assign done_id = sel;
    assign busy    = (state_q != IDLE);

endmodule
